// File: rtl/squat.sv
// squat: ATM UNI-to-NNI cell switch with a CPU-programmed VPI/forward table.
// One cell is buffered, relabelled, given a fresh HEC, then copied to each selected port.
module squat #(
    parameter int NumRx = 4,
    parameter int NumTx = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic [NumRx-1:0]   rx_clk_o,
    input  logic [8*NumRx-1:0] rx_data_i,
    input  logic [NumRx-1:0]   rx_soc_i,
    input  logic [NumRx-1:0]   rx_clav_i,
    output logic [NumRx-1:0]   rx_en_o,
    output logic [NumTx-1:0]   tx_clk_o,
    output logic [8*NumTx-1:0] tx_data_o,
    output logic [NumTx-1:0]   tx_soc_o,
    output logic [NumTx-1:0]   tx_en_o,
    input  logic [NumTx-1:0]   tx_clav_i,
    input  logic               busmode_i,
    input  logic [11:0]        addr_i,
    input  logic               sel_i,
    input  logic               rd_ds_i,
    input  logic               wr_rw_i,
    input  logic [15:0]        data_i,
    output logic [15:0]        data_o,
    output logic               rdy_dtack_o
);
    localparam int RW = (NumRx > 1) ? $clog2(NumRx) : 1;
    localparam int TW = (NumTx > 1) ? $clog2(NumTx) : 1;
    localparam logic [5:0] LastByte = 6'd52;
    localparam logic [5:0] CellLen = 6'd53;

    typedef enum logic [1:0] {Idle, Recv, Lookup, Xmit} state_e;

    state_e           state_q, state_d;
    logic [RW-1:0]    rr_q, port_q, pick, pick_nxt;
    logic             found;
    logic [5:0]       cnt_q;
    logic             lk_q;
    logic [7:0]       buf_q [53];
    logic [11:0]      vpi_q;
    logic [NumTx-1:0] fwd_q, pend_q, tx_en_q;
    logic [TW-1:0]    txp_q, nxt_tx;
    logic             sending_q;
    logic [7:0]       tx_byte_q;
    logic             tx_soc_q;
    logic [11:0]      vpi_tab_q [256];
    logic [NumTx-1:0] fwd_tab_q [256];
    logic             acc, acc_q, start, rdy_q;
    logic [15:0]      dout_q;
    logic [7:0]       rx_byte, uni_vpi;
    logic             rx_soc, take;
    logic             unused;
    int               idx;

    function automatic logic [7:0] hec(input logic [31:0] h);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ h[i]) ? 8'h07 : 8'h00);
        end
        return c ^ 8'h55;
    endfunction

    assign rx_clk_o = {NumRx{clk_i}};
    assign tx_clk_o = {NumTx{clk_i}};
    assign unused   = ^{busmode_i, addr_i[11:9], data_i[15:12]};

    assign rx_byte = rx_data_i[{port_q, 3'b000} +: 8];
    assign rx_soc  = rx_soc_i[port_q];
    assign take    = (cnt_q != 6'd0) || rx_soc;
    assign uni_vpi = {buf_q[0][3:0], buf_q[1][7:4]};

    // Lowest k wins, so the scan starts at rr_q and wraps.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = 0;
        for (int k = NumRx - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NumRx) idx = idx - NumRx;
            if (rx_clav_i[RW'(idx)]) begin
                found = 1'b1;
                pick  = RW'(idx);
            end
        end
        pick_nxt = (int'(pick) == NumRx - 1) ? '0 : pick + RW'(1);
    end

    always_comb begin
        nxt_tx = '0;
        for (int j = NumTx - 1; j >= 0; j--) begin
            if (pend_q[j]) nxt_tx = TW'(j);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle:   if (found) state_d = Recv;
            Recv:   if (cnt_q == LastByte) state_d = Lookup;
            Lookup: if (lk_q) state_d = (fwd_q == '0) ? Idle : Xmit;
            Xmit:   if (!sending_q && pend_q == '0) state_d = Idle;
        endcase
    end

    always_comb begin
        rx_en_o = '1;
        if (state_q == Recv) rx_en_o[port_q] = 1'b0;
        for (int j = 0; j < NumTx; j++) begin
            tx_data_o[j*8 +: 8] = tx_en_q[j] ? 8'h00 : tx_byte_q;
            tx_soc_o[j]         = tx_soc_q & ~tx_en_q[j];
        end
    end

    assign tx_en_o = tx_en_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            rr_q      <= '0;
            port_q    <= '0;
            cnt_q     <= '0;
            lk_q      <= 1'b0;
            vpi_q     <= '0;
            fwd_q     <= '0;
            pend_q    <= '0;
            txp_q     <= '0;
            sending_q <= 1'b0;
            tx_en_q   <= '1;
            tx_byte_q <= '0;
            tx_soc_q  <= 1'b0;
            for (int i = 0; i < 53; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                Idle: begin
                    if (found) begin
                        port_q <= pick;
                        rr_q   <= pick_nxt;
                        cnt_q  <= '0;
                    end
                end
                Recv: begin
                    if (take) begin
                        buf_q[cnt_q] <= rx_byte;
                        cnt_q        <= cnt_q + 6'd1;
                    end
                end
                Lookup: begin
                    lk_q <= ~lk_q;
                    if (!lk_q) begin
                        vpi_q <= vpi_tab_q[uni_vpi];
                        fwd_q <= fwd_tab_q[uni_vpi];
                    end else begin
                        buf_q[0]  <= vpi_q[11:4];
                        buf_q[1]  <= {vpi_q[3:0], buf_q[1][3:0]};
                        buf_q[4]  <= hec({vpi_q, buf_q[1][3:0],
                                          buf_q[2], buf_q[3]});
                        pend_q    <= fwd_q;
                        sending_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                Xmit: begin
                    if (!sending_q) begin
                        if (pend_q != '0 && tx_clav_i[nxt_tx]) begin
                            sending_q       <= 1'b1;
                            txp_q           <= nxt_tx;
                            tx_en_q[nxt_tx] <= 1'b0;
                            tx_byte_q       <= buf_q[0];
                            tx_soc_q        <= 1'b1;
                            cnt_q           <= 6'd1;
                        end
                    end else if (cnt_q != CellLen) begin
                        tx_byte_q <= buf_q[cnt_q];
                        tx_soc_q  <= 1'b0;
                        cnt_q     <= cnt_q + 6'd1;
                    end else begin
                        tx_en_q       <= '1;
                        tx_byte_q     <= '0;
                        tx_soc_q      <= 1'b0;
                        sending_q     <= 1'b0;
                        pend_q[txp_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A held strobe counts as one access; it must rise before the next.
    assign acc   = ~sel_i & (~rd_ds_i | ~wr_rw_i);
    assign start = acc & ~acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= 1'b0;
            rdy_q  <= 1'b0;
            dout_q <= '0;
            for (int i = 0; i < 256; i++) begin
                vpi_tab_q[i] <= '0;
                fwd_tab_q[i] <= '0;
            end
        end else begin
            acc_q <= acc;
            rdy_q <= start;
            if (start && !wr_rw_i) begin
                if (addr_i[8]) fwd_tab_q[addr_i[7:0]] <= data_i[NumTx-1:0];
                else           vpi_tab_q[addr_i[7:0]] <= data_i[11:0];
            end
            if (start && !rd_ds_i) begin
                dout_q <= addr_i[8] ? 16'(fwd_tab_q[addr_i[7:0]])
                                    : 16'(vpi_tab_q[addr_i[7:0]]);
            end
        end
    end

    assign data_o      = dout_q;
    assign rdy_dtack_o = rdy_q;
endmodule

// File: tb/tb_squat.sv
// tb_squat: scoreboard bench for the squat cell switch.
// Rx PHY queues feed cells; expected Tx bytes are queued at send time.
module tb_squat;
    localparam int NR = 4;
    localparam int NT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   rx_clk, rx_en;
    logic [NR-1:0]   rx_soc = '0;
    logic [NR-1:0]   rx_clav = '0;
    logic [8*NR-1:0] rx_data = '0;
    logic [NT-1:0]   tx_clk, tx_soc, tx_en;
    logic [NT-1:0]   tx_clav = '1;
    logic [8*NT-1:0] tx_data;
    logic            busmode = 1'b0;
    logic [11:0]     addr = '0;
    logic            sel_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [15:0]     din = '0, dout;
    logic            rdy;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       soc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [8:0]    rxq [NR][$];
    logic [11:0]   m_vpi [256];
    logic [NT-1:0] m_fwd [256];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    squat #(.NumRx(NR), .NumTx(NT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_clk_o(rx_clk), .rx_data_i(rx_data), .rx_soc_i(rx_soc),
        .rx_clav_i(rx_clav), .rx_en_o(rx_en),
        .tx_clk_o(tx_clk), .tx_data_o(tx_data), .tx_soc_o(tx_soc),
        .tx_en_o(tx_en), .tx_clav_i(tx_clav),
        .busmode_i(busmode), .addr_i(addr), .sel_i(sel_n),
        .rd_ds_i(rd_n), .wr_rw_i(wr_n), .data_i(din),
        .data_o(dout), .rdy_dtack_o(rdy)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_byte(logic [7:0] c, logic [7:0] d);
        c = c ^ d;
        for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    function automatic logic rx_busy();
        for (int i = 0; i < NR; i++) if (rxq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            m_vpi[i] = '0;
            m_fwd[i] = '0;
        end
    endtask

    // Rx PHY: a byte is presented for the edge that follows a low enable.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (!rx_en[i] && rxq[i].size() != 0) begin
                {rx_soc[i], rx_data[i*8 +: 8]} = rxq[i].pop_front();
            end else begin
                rx_soc[i]         = 1'b0;
                rx_data[i*8 +: 8] = 8'h00;
            end
            rx_clav[i] = (rxq[i].size() != 0);
        end
    end

    // Tx monitor: every enabled byte must be the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < NT; j++) begin
                if (!tx_en[j]) begin
                    if (sb.size() != 0) mon_e = sb.pop_front();
                    else begin
                        mon_e.port = 255;
                        mon_e.data = 8'h00;
                        mon_e.soc  = 1'b0;
                    end
                    check("tx_port", j, mon_e.port);
                    check("tx_data", tx_data[j*8 +: 8], mon_e.data);
                    check("tx_soc", tx_soc[j], mon_e.soc);
                end else begin
                    check("tx_idle", {tx_soc[j], tx_data[j*8 +: 8]}, 0);
                end
            end
        end
    end

    task automatic cpu_access(logic is_rd, logic [11:0] a, logic [15:0] d,
                              output logic [15:0] q);
        @(negedge clk);
        sel_n = 1'b0;
        addr  = a;
        din   = d;
        if (is_rd) rd_n = 1'b0;
        else       wr_n = 1'b0;
        @(negedge clk);
        check("cpu_rdy_pulse", rdy, 1);
        q     = dout;
        sel_n = 1'b1;
        rd_n  = 1'b1;
        wr_n  = 1'b1;
        @(negedge clk);
        check("cpu_rdy_clear", rdy, 0);
    endtask

    task automatic cpu_write(logic [11:0] a, logic [15:0] d);
        logic [15:0] q;
        cpu_access(1'b0, a, d, q);
        if (a[8]) m_fwd[a[7:0]] = d[NT-1:0];
        else      m_vpi[a[7:0]] = d[11:0];
    endtask

    task automatic cpu_read(string tag, logic [11:0] a);
        logic [15:0] q, e;
        cpu_access(1'b1, a, 16'h0000, q);
        e = a[8] ? 16'(m_fwd[a[7:0]]) : 16'(m_vpi[a[7:0]]);
        check(tag, q, e);
    endtask

    task automatic send_cell(int port, logic [3:0] gfc, logic [7:0] vpi,
                             logic [15:0] vci, logic [3:0] clp_pt, int garbage);
        logic [7:0]    c [53];
        logic [7:0]    n0, n1, h, b;
        logic [NT-1:0] fwd;
        exp_t          e;
        c[0] = {gfc, vpi[7:4]};
        c[1] = {vpi[3:0], vci[15:12]};
        c[2] = vci[11:4];
        c[3] = {vci[3:0], clp_pt};
        for (int k = 4; k < 53; k++) c[k] = 8'($urandom);
        for (int g = 0; g < garbage; g++) rxq[port].push_back({1'b0, 8'($urandom)});
        for (int k = 0; k < 53; k++) rxq[port].push_back({k == 0, c[k]});
        n0  = m_vpi[vpi][11:4];
        n1  = {m_vpi[vpi][3:0], vci[15:12]};
        h   = crc_byte(crc_byte(crc_byte(crc_byte(8'h00, n0), n1), c[2]), c[3]);
        h   = h ^ 8'h55;
        fwd = m_fwd[vpi];
        for (int j = 0; j < NT; j++) begin
            if (fwd[j]) begin
                for (int k = 0; k < 53; k++) begin
                    b = c[k];
                    if (k == 0) b = n0;
                    if (k == 1) b = n1;
                    if (k == 4) b = h;
                    e.port = j;
                    e.data = b;
                    e.soc  = (k == 0);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || rx_busy()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, n < 3000, 1);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_en", tx_en, 4'hF);
        check("rst_rx_en", rx_en, 4'hF);
        check("rst_dout", dout, 0);
        check("rst_rdy", rdy, 0);
        rst_n = 1'b1;

        cpu_read("rd_vpi_00", 12'h000);
        cpu_read("rd_fwd_00", 12'h100);
        cpu_write(12'h012, 16'h0ABC);
        cpu_write(12'h112, 16'h0005);
        cpu_read("rd_vpi_12", 12'h012);
        cpu_read("rd_fwd_12", 12'h112);

        send_cell(0, 4'h0, 8'h12, 16'h3456, 4'h2, 0);
        wait_idle("cell12");
        send_cell(0, 4'hF, 8'h12, 16'hBEEF, 4'h9, 3);
        wait_idle("gfc_garbage");

        send_cell(0, 4'h0, 8'h33, 16'h0001, 4'h0, 0);
        wait_idle("drop");
        check("drop_rx_taken", rxq[0].size(), 0);
        send_cell(0, 4'h3, 8'h12, 16'h7001, 4'h1, 0);
        wait_idle("after_drop");

        cpu_write(12'h040, 16'h0140);
        cpu_write(12'h140, 16'h0001);
        cpu_write(12'h041, 16'h0FFF);
        cpu_write(12'h141, 16'h0008);
        send_cell(1, 4'h0, 8'h40, 16'h1111, 4'h0, 0);
        send_cell(3, 4'h0, 8'h41, 16'h3333, 4'h0, 0);
        send_cell(1, 4'h0, 8'h40, 16'h1112, 4'h0, 0);
        send_cell(3, 4'h0, 8'h41, 16'h3334, 4'h0, 0);
        wait_idle("round_robin");

        cpu_write(12'h050, 16'h0777);
        cpu_write(12'h150, 16'h0004);
        tx_clav[2] = 1'b0;
        send_cell(0, 4'h0, 8'h50, 16'h5555, 4'h4, 0);
        repeat (150) @(negedge clk);
        check("hold_tx_en", tx_en, 4'hF);
        check("hold_pending", sb.size(), 53);
        cpu_write(12'h050, 16'h0111);
        cpu_write(12'h150, 16'h0001);
        tx_clav[2] = 1'b1;
        wait_idle("hold_release");

        cpu_read("rd_vpi_12_pre", 12'h012);
        send_cell(0, 4'h0, 8'h12, 16'h9876, 4'h0, 0);
        n = 0;
        while (sb.size() > 106 - 20 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rst_wait", n < 2000, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_en", tx_en, 4'hF);
        check("mid_rst_tx_soc", tx_soc, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_rdy", rdy, 0);
        sb.delete();
        for (int i = 0; i < NR; i++) rxq[i].delete();
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cpu_read("rd_vpi_12_post", 12'h012);
        cpu_read("rd_fwd_12_post", 12'h112);
        send_cell(0, 4'h0, 8'h12, 16'h4321, 4'h0, 0);
        wait_idle("post_rst_drop");
        cpu_write(12'h012, 16'h05A5);
        cpu_write(12'h112, 16'h0002);
        send_cell(0, 4'h0, 8'h12, 16'h4322, 4'h0, 0);
        wait_idle("reprogrammed");

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
